// File: rtl/phoenix_packet_sender.sv
// Phoenix router packet injector: emits header, size and payload flits over a credit-based link.
// Define PHOENIX_SENDER_STATS_EN to add packet/flit/stall counters (stat_pkts, stat_flits, stat_stall).
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module phoenix_packet_sender #(
  parameter int FLIT_W = `TAM_FLIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_start,
  input  logic [FLIT_W-1:0] pkt_target,
  input  logic [FLIT_W-1:0] pkt_size,
  output logic              pkt_busy,
  output logic              pkt_done,
  output logic              pkt_err,
  input  logic              pay_valid,
  input  logic [FLIT_W-1:0] pay_data,
  output logic              pay_ready,
  output logic              tx,
  output logic [FLIT_W-1:0] data_out,
  input  logic              credit_i,
`ifdef PHOENIX_SENDER_STATS_EN
  output logic [31:0]       stat_pkts,
  output logic [31:0]       stat_flits,
  output logic [31:0]       stat_stall,
`endif
  output logic              clock_tx
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SIZE, S_PAY, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [FLIT_W-1:0] rem_q, rem_d;
  logic [FLIT_W-1:0] data_q, data_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              out_free;
  logic              accept;

  assign xfer     = tx_q & credit_i;
  assign out_free = ~tx_q | credit_i;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    data_d    = data_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pay_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pkt_start) begin
          if (pkt_size != '0) begin
            rem_d   = pkt_size;
            data_d  = pkt_target;
            tx_d    = 1'b1;
            state_d = S_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        // rem still holds the full size until the first payload word is accepted
        if (xfer) begin
          data_d  = rem_q;
          tx_d    = 1'b1;
          state_d = S_SIZE;
        end
      end
      S_SIZE: begin
        pay_ready = xfer;
        if (xfer) begin
          tx_d    = 1'b0;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        pay_ready = out_free;
        if (xfer) tx_d = 1'b0;
      end
      S_DRAIN: begin
        if (xfer) begin
          tx_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A payload accept overrides the bubble and, on the last word, jumps to DRAIN
    accept = pay_valid & pay_ready;
    if (accept) begin
      data_d = pay_data;
      tx_d   = 1'b1;
      rem_d  = rem_q - FLIT_W'(1);
      if (rem_q == FLIT_W'(1)) state_d = S_DRAIN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pkt_busy = (state_q != S_IDLE);
  assign pkt_done = done_q;
  assign pkt_err  = err_q;
  assign tx       = tx_q;
  assign data_out = data_q;
  assign clock_tx = clock;

`ifdef PHOENIX_SENDER_STATS_EN
  logic [31:0] pkts_q, pkts_d;
  logic [31:0] flits_q, flits_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    pkts_d  = pkts_q + (done_q ? 32'd1 : 32'd0);
    flits_d = flits_q + (xfer ? 32'd1 : 32'd0);
    stall_d = stall_q + ((tx_q & ~credit_i) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pkts_q  <= '0;
      flits_q <= '0;
      stall_q <= '0;
    end else begin
      pkts_q  <= pkts_d;
      flits_q <= flits_d;
      stall_q <= stall_d;
    end
  end

  assign stat_pkts  = pkts_q;
  assign stat_flits = flits_q;
  assign stat_stall = stall_q;
`endif

endmodule
